// File: rtl/uart_pkg.sv
// Shared UART types and default frame constants.
// Used by the TX path (uart_fifo_tx) and its UART-level siblings.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_SB_TICK    = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Keeps counters at least 1 bit wide for degenerate parameters.
    function automatic int clog2_min1(input int v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/uart_fifo_tx.sv
// UART transmitter draining the TX FIFO read side onto the serial pad.
// Optional even-parity bit is compiled in with `define UART_TX_PARITY_EN.
module uart_fifo_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int SB_TICK    = UART_SB_TICK
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_tick,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done_tick
);

    localparam int TW = clog2_min1(max_int(OVERSAMPLE, SB_TICK));
    localparam int BW = clog2_min1(DATA_WIDTH);
    localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    tx_state_t             state_q, state_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                  par_q, par_d;
`endif

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        done_d  = 1'b0;
        fifo_rd = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_rd = 1'b1;
                    sr_d    = fifo_rd_data;
                    tick_d  = '0;
                    bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^fifo_rd_data;
`endif
                    state_d = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_q == OS_LAST) begin
                        tick_d  = '0;
                        state_d = DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_q == OS_LAST) begin
                        tick_d = '0;
                        sr_d   = sr_q >> 1;
                        bit_d  = bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (tick_q == OS_LAST) begin
                        tick_d  = '0;
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (tick_q == SB_LAST) begin
                        tick_d  = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the state being entered, so tx is registered.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sr_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase

        if (reset) fifo_rd = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx           = tx_q;
    assign tx_busy      = (state_q != IDLE);
    assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Randomised bench for uart_fifo_tx against a per-cycle frame model.
// Define UART_TX_PARITY_EN for both DUT and bench to cover parity.
module tb_uart_fifo_tx;
    import uart_pkg::*;

    localparam int DW = 8;
    localparam int OS = 16;
    localparam int SB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int TOTAL = (1 + DW + P) * OS + SB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_tick = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd, tx, tx_busy, tx_done_tick;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];
    int  tick_mode = 0;
    int  div5 = 0;
    bit  active = 1'b0;
    bit  just_done = 1'b0;
    int  t = 0;
    logic [DW-1:0] word = '0;
    bit  p_reset = 1'b1;
    bit  p_tick = 1'b0;
    bit  p_pop = 1'b0;
    int  pops = 0;
    int  dones = 0;
    int  sent = 0;

    uart_fifo_tx #(
        .DATA_WIDTH(DW),
        .OVERSAMPLE(OS),
        .SB_TICK(SB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .s_tick(s_tick),
        .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data),
        .fifo_rd(fifo_rd),
        .tx(tx),
        .tx_busy(tx_busy),
        .tx_done_tick(tx_done_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void refresh();
        fifo_empty   = (q.size() == 0);
        fifo_rd_data = (q.size() == 0) ? '0 : q[0];
    endfunction

    // Frame bit index: 0 start, 1..DW data LSB first, then parity, then stop.
    function automatic logic exp_bit(input logic [DW-1:0] w, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DW) return w[idx-1];
        if (P == 1 && idx == DW + 1) return ($countones(w) % 2) == 1;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        #1;
        case (tick_mode)
            0: s_tick = 1'b1;
            1: begin
                s_tick = (div5 == 4);
                div5 = (div5 == 4) ? 0 : div5 + 1;
            end
            2: s_tick = ($urandom_range(0, 2) == 0);
            default: s_tick = 1'b0;
        endcase
    end

    // Model advances on what the DUT sampled at the last edge.
    always @(negedge clk) begin
        just_done = 1'b0;
        if (p_reset) begin
            active = 1'b0;
        end else if (active) begin
            if (p_tick) t++;
            if (t == TOTAL) begin
                active = 1'b0;
                just_done = 1'b1;
                dones++;
            end
        end else if (p_pop && q.size() > 0) begin
            word = q.pop_front();
            active = 1'b1;
            t = 0;
            pops++;
        end
        refresh();
        chk("tx", 32'(tx), 32'(active ? exp_bit(word, t / OS) : 1'b1));
        chk("busy", 32'(tx_busy), 32'(active));
        chk("done", 32'(tx_done_tick), 32'(just_done));
        chk("rd", 32'(fifo_rd), 32'(!active && !fifo_empty && !reset));
        p_reset = reset;
        p_tick  = s_tick;
        p_pop   = fifo_rd;
    end

    task automatic push(input logic [DW-1:0] w);
        @(posedge clk);
        #1;
        q.push_back(w);
        sent++;
        refresh();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((q.size() != 0 || active) && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 32'(q.size() == 0 && !active), 32'(1));
        repeat (3) @(posedge clk);
    endtask

    initial begin
        q.push_back(8'h3C);
        sent++;
        refresh();
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        wait_idle(1000);

        push(8'hA5);
        wait_idle(1000);

        push(8'h00);
        push(8'hFF);
        wait_idle(1000);

        push(8'h07);
        push(8'h03);
        wait_idle(1000);

        push(8'h5A);
        repeat (70) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (40) @(posedge clk);

        tick_mode = 1;
        push(8'h81);
        repeat (300) @(posedge clk);
        tick_mode = 3;
        repeat (100) @(posedge clk);
        tick_mode = 1;
        wait_idle(2000);

        tick_mode = 2;
        for (int i = 0; i < 10; i++) begin
            push(DW'($urandom));
            repeat ($urandom_range(0, 400)) @(posedge clk);
        end
        wait_idle(12000);

        tick_mode = 0;
        for (int i = 0; i < 3; i++) push(DW'($urandom));
        wait_idle(1000);

        chk("pops", 32'(pops), 32'(sent));
        chk("dones", 32'(dones), 32'(sent - 1));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/uart_fifo_tx.md
# uart_fifo_tx

UART transmitter that drains the TX FIFO from its read side. Whenever the FIFO is non-empty and the line is idle, it pops one word and serialises it onto `tx` as start, data (LSB first), optional parity and stop bits, paced by the shared oversampling baud tick. It sits between the UART TX FIFO (combinational read port) and the pad. It is the counterpart of the UART receive path.

## Interface
- `DATA_WIDTH`, 8: data bits per frame.
- `OVERSAMPLE`, 16: `s_tick` pulses per start/data/parity bit.
- `SB_TICK`, 16: `s_tick` pulses for the stop period. 16 gives 1 stop bit, 24 gives 1.5, 32 gives 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `s_tick`  in  1  one-clk baud oversample strobe.
- `fifo_empty`  in  1  TX FIFO empty flag.
- `fifo_rd_data`  in  DATA_WIDTH  FIFO head word, valid in the same cycle as `!fifo_empty`.
- `fifo_rd`  out  1  one-clk pop strobe to the FIFO.
- `tx`  out  1  serial line, registered, idle high.
- `tx_busy`  out  1  high from the pop until the frame ends.
- `tx_done_tick`  out  1  one-clk pulse at the end of the stop period.

## Operation
- The FSM has five states: IDLE, START, DATA, PARITY, STOP. Its registers are a tick counter (width `$clog2(max(OVERSAMPLE,SB_TICK))`), a bit counter (`$clog2(DATA_WIDTH)`), and a shift register.
- IDLE:
  - If `!fifo_empty`, assert `fifo_rd` combinationally in the same cycle, load `fifo_rd_data` into the shift register, clear the counters and go to START.
  - `fifo_empty` is ignored in every other state.
- START: drive `tx`=0. On each `s_tick`, increment the tick counter. On the `s_tick` where the counter equals OVERSAMPLE-1, clear it and go to DATA.
- DATA:
  - `tx` = shift register bit 0.
  - At each OVERSAMPLE-1 tick boundary, shift right and increment the bit counter.
  - After bit DATA_WIDTH-1, go to PARITY if parity is enabled, otherwise go to STOP.
- PARITY: drive `tx` = even-parity bit of the popped word for OVERSAMPLE ticks, then go to STOP.
- STOP:
  - Drive `tx`=1 for SB_TICK ticks.
  - On the final `s_tick`, pulse `tx_done_tick` and return to IDLE.
- Back-to-back frames: IDLE re-examines `fifo_empty` in the cycle after the return. The gap between frames is exactly 1 clk of idle-high, with no extra baud periods.
- `s_tick` absent: the FSM holds state and `tx` holds its value indefinitely.
- Reset:
  - On reset, every output takes its reset value: `tx`=1, `fifo_rd`=0, `tx_busy`=0, `tx_done_tick`=0. The FSM returns to IDLE and the counters clear.
  - Reset mid-frame aborts the frame. The popped word is lost, no `tx_done_tick` is produced, and no pop occurs in the reset cycle.
- `reset` takes priority over all other inputs.

## Timing
- Pop to start bit: `fifo_rd` is high in cycle N, and `tx` falls at the clk edge ending cycle N (registered output).
- Frame length in `s_tick` pulses: (1 + DATA_WIDTH + P)·OVERSAMPLE + SB_TICK, where P=1 with parity enabled and 0 otherwise.
- Each bit boundary falls on the clk edge of the qualifying `s_tick`.
- `tx_busy` goes high in the edge after the pop cycle and goes low on the same edge that `tx_done_tick` goes high.
- `tx_done_tick` is 1 clk wide and `fifo_rd` is 1 clk wide. Neither is ever asserted in consecutive cycles.

## Configuration
- Macro `UART_TX_PARITY_EN`.
- When defined, the PARITY state and a parity register are compiled in. Each frame carries an even-parity bit after the data: the bit is 1 if the data has an odd number of ones.
- When undefined, the PARITY state does not exist and the frame goes DATA→STOP.

## Structure
- Shared package `uart_pkg` holds:
  - `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP; PARITY is present regardless of the macro);
  - the default constants `UART_DATA_WIDTH`=8, `UART_OVERSAMPLE`=16, `UART_SB_TICK`=16.
- No sub-module. The baud tick generator and the FIFO are instantiated alongside this block at UART top level.

## Test plan
All scenarios use DATA_WIDTH=8, OVERSAMPLE=16, SB_TICK=16, and `s_tick` every clk unless stated.
1. Reset with the FIFO non-empty → `tx`=1, `fifo_rd`=0, `tx_busy`=0 throughout reset. The first pop occurs in the first cycle after reset deasserts.
2. Single word 0xA5 → exactly one `fifo_rd` pulse. `tx` carries 0,1,0,1,0,0,1,0,1,1 with each bit lasting 16 clk. `tx_done_tick` fires 160 clk after the pop, then `tx` stays 1.
3. Words 0x00 then 0xFF queued → two `fifo_rd` pulses 161 clk apart. The second start bit begins 1 clk after the first `tx_done_tick`.
4. With `UART_TX_PARITY_EN` defined, send 0x07 → parity bit 1. Send 0x03 → parity bit 0. Frame length is 176 clk.
5. Assert `reset` during data bit 3 of 0x5A → `tx`=1 on the next edge, `tx_busy`=0, no `tx_done_tick`, and no further `fifo_rd` while the FIFO is empty.
6. `s_tick` every 5th clk, send 0x81 → each bit lasts 80 clk. Stalling `s_tick` for 100 clk mid-bit freezes `tx` with no bit skipped.
